// File: rtl/des_pkg.sv
// DES constants and helpers: permutation tables, S-boxes, key shift schedule, FSM state type.
// Latency: n/a (pure functions and constants, combinational when used).
// Backpressure: n/a.
// Tables use FIPS 46-3 numbering: entry value n selects input bit n, where bit 1 is the MSB.
package des_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_REQ_LOW,
      ST_CRYPT,
      ST_OUTPUT
   } state_t;

   localparam int unsigned IP_T [0:63] = '{
      58, 50, 42, 34, 26, 18, 10,  2,  60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6,  64, 56, 48, 40, 32, 24, 16,  8,
      57, 49, 41, 33, 25, 17,  9,  1,  59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5,  63, 55, 47, 39, 31, 23, 15,  7};

   localparam int unsigned FP_T [0:63] = '{
      40,  8, 48, 16, 56, 24, 64, 32,  39,  7, 47, 15, 55, 23, 63, 31,
      38,  6, 46, 14, 54, 22, 62, 30,  37,  5, 45, 13, 53, 21, 61, 29,
      36,  4, 44, 12, 52, 20, 60, 28,  35,  3, 43, 11, 51, 19, 59, 27,
      34,  2, 42, 10, 50, 18, 58, 26,  33,  1, 41,  9, 49, 17, 57, 25};

   localparam int unsigned E_T [0:47] = '{
      32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

   localparam int unsigned P_T [0:31] = '{
      16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

   // Parity bits 8,16,...,64 never appear, so they are dropped here.
   localparam int unsigned PC1_T [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

   localparam int unsigned PC2_T [0:47] = '{
      14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

   localparam int unsigned SHIFT_T [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // Indexed [box][row*16 + col].
   localparam int unsigned SBOX_T [0:7][0:63] = '{
      '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
      '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
      '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
      '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
      '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
      '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
      '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
      '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

   function automatic logic [63:0] f_ip(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
      return y;
   endfunction

   function automatic logic [63:0] f_fp(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
      return y;
   endfunction

   function automatic logic [47:0] f_e(input logic [31:0] x);
      logic [47:0] y;
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
      return y;
   endfunction

   function automatic logic [31:0] f_p(input logic [31:0] x);
      logic [31:0] y;
      for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
      return y;
   endfunction

   function automatic logic [55:0] f_pc1(input logic [63:0] x);
      logic [55:0] y;
      for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
      return y;
   endfunction

   function automatic logic [47:0] f_pc2(input logic [55:0] x);
      logic [47:0] y;
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
      return y;
   endfunction

   // Row is the outer bit pair of each 6-bit group, column the inner four bits.
   function automatic logic [31:0] f_sbox(input logic [47:0] x);
      logic [31:0] y;
      logic [5:0]  b;
      for (int s = 0; s < 8; s++) begin
         b = x[6'(47 - 6 * s) -: 6];
         y[5'(31 - 4 * s) -: 4] = 4'(SBOX_T[3'(s)][{b[5], b[0], b[4:1]}]);
      end
      return y;
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
      case (n)
         2'd1:    return {x[26:0], x[27]};
         2'd2:    return {x[25:0], x[27:26]};
         default: return x;
      endcase
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
      case (n)
         2'd1:    return {x[0], x[27:1]};
         2'd2:    return {x[1:0], x[27:2]};
         default: return x;
      endcase
   endfunction

endpackage

// File: rtl/des_round.sv
// One DES Feistel round: E-expansion, subkey XOR, S-boxes, P, then L/R swap.
// Latency: combinational.
// Backpressure: none.
// Ports: i_l/i_r round input halves, i_key 48-bit subkey, o_l/o_r round output halves.
module des_round
   import des_pkg::*;
(
   input  logic [31:0] i_l,
   input  logic [31:0] i_r,
   input  logic [47:0] i_key,
   output logic [31:0] o_l,
   output logic [31:0] o_r
);

   logic [47:0] w_x;

   assign w_x = f_e(i_r) ^ i_key;
   assign o_l = i_r;
   assign o_r = i_l ^ f_p(f_sbox(w_x));

endmodule

// File: rtl/des_byte_engine.sv
// Byte-serial DES engine: collects key+plaintext over a 4-phase req/ack handshake, runs 16 rounds, streams ciphertext.
// Latency: 16 clk of rounds after the 16th handshake, then 8 bytes each held OUT_HOLD clk.
// Backpressure: req is not acknowledged while busy; a pending req is serviced on return to IDLE.
// Ports: clk, rst_n (async active-low), din/req in, ack out, dout byte stream, busy (rounds + output).
// Option: DES_DECRYPT_EN adds the decrypt input (sampled entering CRYPT) selecting reversed key schedule.
module des_byte_engine
   import des_pkg::*;
#(
   parameter int OUT_HOLD = 8
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] din,
   input  logic       req,
`ifdef DES_DECRYPT_EN
   input  logic       decrypt,
`endif
   output logic       ack,
   output logic [7:0] dout,
   output logic       busy
);

   localparam logic [7:0] HOLD_LAST = 8'(OUT_HOLD - 1);

   state_t      r_state;
   logic        r_req_meta;
   logic        r_req_s;
   logic [4:0]  r_cnt;
   logic [63:0] r_key;
   logic [63:0] r_data;
   logic [31:0] r_l;
   logic [31:0] r_r;
   logic [27:0] r_c;
   logic [27:0] r_d;
   logic [3:0]  r_rnd;
   logic [63:0] r_ct;
   logic [2:0]  r_oidx;
   logic [7:0]  r_hold;

   logic        w_dec;
   logic [3:0]  w_didx;
   logic [1:0]  w_shl;
   logic [1:0]  w_shr;
   logic [27:0] w_c;
   logic [27:0] w_d;
   logic [47:0] w_subkey;
   logic [31:0] w_l_nxt;
   logic [31:0] w_r_nxt;
   logic [63:0] w_ct;
   logic [7:0]  w_nbyte;

`ifdef DES_DECRYPT_EN
   logic        r_dec;
   assign w_dec = r_dec;
`else
   assign w_dec = 1'b0;
`endif

   // Decryption walks the schedule backwards: round 0 uses C16/D16 (== C0/D0) unshifted,
   // round n>0 undoes the shift of encryption round 16-n.
   assign w_didx = 4'd0 - r_rnd;
   assign w_shl  = 2'(SHIFT_T[r_rnd]);
   assign w_shr  = (r_rnd == 4'd0) ? 2'd0 : 2'(SHIFT_T[w_didx]);
   assign w_c    = w_dec ? rotr28(r_c, w_shr) : rotl28(r_c, w_shl);
   assign w_d    = w_dec ? rotr28(r_d, w_shr) : rotl28(r_d, w_shl);
   assign w_subkey = f_pc2({w_c, w_d});

   des_round u_round (
      .i_l   (r_l),
      .i_r   (r_r),
      .i_key (w_subkey),
      .o_l   (w_l_nxt),
      .o_r   (w_r_nxt)
   );

   // Final swap (R16 before L16) folded into the FP input.
   assign w_ct    = f_fp({w_r_nxt, w_l_nxt});
   assign w_nbyte = r_ct[{r_oidx + 3'd1, 3'b000} +: 8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_req_meta <= 1'b0;
         r_req_s    <= 1'b0;
         r_cnt      <= '0;
         r_key      <= '0;
         r_data     <= '0;
         r_l        <= '0;
         r_r        <= '0;
         r_c        <= '0;
         r_d        <= '0;
         r_rnd      <= '0;
         r_ct       <= '0;
         r_oidx     <= '0;
         r_hold     <= '0;
         ack        <= 1'b0;
         busy       <= 1'b0;
         dout       <= 8'h00;
`ifdef DES_DECRYPT_EN
         r_dec      <= 1'b0;
`endif
      end else begin
         r_req_meta <= req;
         r_req_s    <= r_req_meta;
         case (r_state)
            ST_IDLE, ST_LOAD: begin
               if (r_req_s && !ack) begin
                  // key and data form one 128-bit shift chain, key on top
                  r_key   <= {r_key[55:0], r_data[63:56]};
                  r_data  <= {r_data[55:0], din};
                  r_cnt   <= r_cnt + 5'd1;
                  ack     <= 1'b1;
                  r_state <= ST_WAIT_REQ_LOW;
               end
            end
            ST_WAIT_REQ_LOW: begin
               if (!r_req_s) begin
                  ack <= 1'b0;
                  if (r_cnt == 5'd16) begin
                     r_state    <= ST_CRYPT;
                     busy       <= 1'b1;
                     {r_l, r_r} <= f_ip(r_data);
                     {r_c, r_d} <= f_pc1(r_key);
                     r_rnd      <= 4'd0;
`ifdef DES_DECRYPT_EN
                     r_dec      <= decrypt;
`endif
                  end else begin
                     r_state <= ST_LOAD;
                  end
               end
            end
            ST_CRYPT: begin
               r_l   <= w_l_nxt;
               r_r   <= w_r_nxt;
               r_c   <= w_c;
               r_d   <= w_d;
               r_rnd <= r_rnd + 4'd1;
               if (r_rnd == 4'd15) begin
                  r_state <= ST_OUTPUT;
                  r_ct    <= w_ct;
                  dout    <= w_ct[7:0];
                  r_oidx  <= 3'd0;
                  r_hold  <= 8'd0;
               end
            end
            ST_OUTPUT: begin
               if (r_hold == HOLD_LAST) begin
                  r_hold <= 8'd0;
                  if (r_oidx == 3'd7) begin
                     // dout keeps ct[63:56]
                     r_state <= ST_IDLE;
                     busy    <= 1'b0;
                     r_cnt   <= '0;
                  end else begin
                     r_oidx <= r_oidx + 3'd1;
                     dout   <= w_nbyte;
                  end
               end else begin
                  r_hold <= r_hold + 8'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_des_byte_engine.sv
`timescale 1ns/1ps
module tb_des_byte_engine;

   localparam int          OUT_HOLD = 8;
   localparam int          BUSY_LEN = 16 + 8 * OUT_HOLD;
   localparam logic [63:0] KEY_FIPS = 64'h133457799BBCDFF1;
   localparam logic [63:0] PT_FIPS  = 64'h0123456789ABCDEF;
   localparam logic [63:0] CT_FIPS  = 64'h85E813540F0AB405;
   localparam logic [63:0] V1212    = 64'h1212121212121212;
   localparam logic [63:0] CT_1212  = 64'h96CD27784D1563E5;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       req   = 1'b0;
   logic [7:0] din   = 8'h00;
   logic       ack;
   logic       busy;
   logic [7:0] dout;
`ifdef DES_DECRYPT_EN
   logic       decrypt = 1'b0;
`endif

   int err_cnt = 0;
   int chk_cnt = 0;

   always #5 clk = ~clk;

   des_byte_engine #(.OUT_HOLD(OUT_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din),
      .req   (req),
`ifdef DES_DECRYPT_EN
      .decrypt (decrypt),
`endif
      .ack   (ack),
      .dout  (dout),
      .busy  (busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] load_byte(input logic [63:0] k, input logic [63:0] p, input int i);
      if (i < 8) return k[8 * (7 - i) +: 8];
      return p[8 * (15 - i) +: 8];
   endfunction

   // Full 4-phase handshake for one byte; called and returning on a negedge.
   task automatic send_byte(input logic [7:0] b);
      int n;
      din = b;
      req = 1'b1;
      n = 0;
      while (ack !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      if (n >= 40) chk("ack_rise_timeout", ack, 1);
      req = 1'b0;
      n = 0;
      while (ack !== 1'b0 && n < 40) begin @(negedge clk); n++; end
      if (n >= 40) chk("ack_fall_timeout", ack, 0);
   endtask

   task automatic load(input logic [63:0] k, input logic [63:0] p, input int first, input int last);
      for (int i = first; i <= last; i++) send_byte(load_byte(k, p, i));
   endtask

   // Follows one CRYPT+OUTPUT pass: dout held at prev during CRYPT, each ct byte (LSB first)
   // checked at the first and last cycle of its hold window, busy length, final hold, no ack.
   task automatic run_check(input string tag, input logic [63:0] ct, input logic [7:0] prev,
                            input bit req_mid, input logic [7:0] mid_byte);
      int   n;
      int   i;
      int   k;
      int   pos;
      logic ack_seen;
      n = 0;
      while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk({tag, "_busy_rise"}, busy, 1);
      i = 0;
      ack_seen = 1'b0;
      while (busy === 1'b1 && i < BUSY_LEN + 20) begin
         if (ack === 1'b1) ack_seen = 1'b1;
         if (req_mid && i == 5) begin
            din = mid_byte;
            req = 1'b1;
         end
         if (i == 0 || i == 15) begin
            chk($sformatf("%s_crypt_dout%0d", tag, i), dout, prev);
         end else if (i >= 16) begin
            k   = (i - 16) / OUT_HOLD;
            pos = (i - 16) % OUT_HOLD;
            if (k < 8 && (pos == 0 || pos == OUT_HOLD - 1))
               chk($sformatf("%s_byte%0d_p%0d", tag, k, pos), dout, ct[8 * k +: 8]);
         end
         @(negedge clk);
         i++;
      end
      chk({tag, "_busy_len"}, i, BUSY_LEN);
      chk({tag, "_dout_hold"}, dout, ct[63:56]);
      chk({tag, "_no_ack_busy"}, ack_seen, 0);
   endtask

   initial begin
      int   n;
      int   rises;
      logic prev_ack;
      logic busy_seen;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dout", dout, 8'h00);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // repeated-byte key and plaintext
      load(V1212, V1212, 0, 15);
      run_check("t1", CT_1212, 8'h00, 1'b0, 8'h00);

      // req held for 20 cycles on the first byte: one ack rise, one capture
      din = load_byte(KEY_FIPS, PT_FIPS, 0);
      req = 1'b1;
      rises = 0;
      prev_ack = ack;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (ack === 1'b1 && prev_ack !== 1'b1) rises++;
         prev_ack = ack;
      end
      chk("long_req_rises", rises, 1);
      chk("long_req_ack_high", ack, 1);
      req = 1'b0;
      n = 0;
      while (ack !== 1'b0 && n < 40) begin @(negedge clk); n++; end
      chk("long_req_ack_fall", ack, 0);
      load(KEY_FIPS, PT_FIPS, 1, 15);
      run_check("t2", CT_FIPS, CT_1212[63:56], 1'b0, 8'h00);

      // reset in the middle of a load abandons it
      load(KEY_FIPS, PT_FIPS, 0, 9);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_ack", ack, 0);
      chk("midrst_dout", dout, 8'h00);
      chk("midrst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      busy_seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (busy === 1'b1) busy_seen = 1'b1;
      end
      chk("midrst_no_crypt", busy_seen, 0);
      // fresh load, with a request raised during CRYPT
      load(V1212, V1212, 0, 15);
      run_check("t3", CT_1212, 8'h00, 1'b1, load_byte(KEY_FIPS, PT_FIPS, 0));

      // the request raised while busy is acknowledged once back in IDLE
      n = 0;
      while (ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("t4_ack_idle", ack, 1);
      req = 1'b0;
      n = 0;
      while (ack !== 1'b0 && n < 40) begin @(negedge clk); n++; end
      load(KEY_FIPS, PT_FIPS, 1, 15);
      run_check("t4", CT_FIPS, CT_1212[63:56], 1'b0, 8'h00);

`ifdef DES_DECRYPT_EN
      decrypt = 1'b1;
      load(KEY_FIPS, CT_FIPS, 0, 15);
      run_check("t5_dec", PT_FIPS, CT_FIPS[63:56], 1'b0, 8'h00);
      decrypt = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
